// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: bit-timing defaults and receiver state encoding.
// SIM builds shrink the divider so a frame takes tens of clocks instead of 52k.
package uart_rx_pkg;

`ifdef SIM
  localparam logic [12:0] T_DIV_DEF      = 13'd7;
  localparam logic [12:0] T_DIV_HALF_DEF = 13'd3;
`else
  localparam logic [12:0] T_DIV_DEF      = 13'd5207;
  localparam logic [12:0] T_DIV_HALF_DEF = 13'd2603;
`endif

  localparam int CNT_W  = 13;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines do not fake an edge out of reset.
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, LSB-first data, stop check.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for rxd_s low
// ST_START | counting to mid start bit, then qualify it
// ST_DATA  | sampling 8 data bits, one per bit period
// ST_STOP  | sampling the stop bit
// ST_BREAK | stop bit was low, waiting for line to return high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [12:0] T_DIV      = T_DIV_DEF,
  parameter logic [12:0] T_DIV_HALF = T_DIV_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       busy,
  output logic       clk_rx_en
);

  logic             rxd_s;
  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic half_tc, bit_tc;
  logic counting, cnt_clr, sample, shift_en, done_nxt, ferr_nxt;

  uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  assign half_tc = (cnt == T_DIV_HALF);
  assign bit_tc  = (cnt == T_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!rxd_s) state_nxt = ST_START;
      ST_START: if (half_tc) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_tc && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (bit_tc) state_nxt = rxd_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rxd_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    counting = 1'b0;
    sample   = 1'b0;
    shift_en = 1'b0;
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
    busy     = (state != ST_IDLE);
    cnt_clr  = (state_nxt != state);
    unique case (state)
      ST_START: begin
        counting = 1'b1;
        sample   = half_tc;
      end
      ST_DATA: begin
        counting = 1'b1;
        sample   = bit_tc;
        shift_en = bit_tc;
      end
      ST_STOP: begin
        counting = 1'b1;
        sample   = bit_tc;
        done_nxt = bit_tc && rxd_s;
        ferr_nxt = bit_tc && !rxd_s;
      end
      default: ;
    endcase
  end

  // Registered strobes line up with the dout update one cycle after sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      dout      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      clk_rx_en <= 1'b0;
    end else begin
      done      <= done_nxt;
      frame_err <= ferr_nxt;
      clk_rx_en <= sample;

      if (cnt_clr || sample) cnt <= '0;
      else if (counting)     cnt <= cnt + 13'd1;

      if (state == ST_START) bit_idx <= '0;
      else if (shift_en)     bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift[bit_idx] <= rxd_s;
      if (done_nxt) dout <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: driver pushes expected bytes and done
// times from a frame-level model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV      = 7;
  localparam int HALF_DIV = 3;
  localparam int BIT_CLKS = DIV + 1;
  localparam int LAT      = 3 + (HALF_DIV + 1) + 9 * (DIV + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] dout;
  logic       done, frame_err, busy, clk_rx_en;

  uart_rx #(.T_DIV(13'd7), .T_DIV_HALF(13'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .dout      (dout),
    .done      (done),
    .frame_err (frame_err),
    .busy      (busy),
    .clk_rx_en (clk_rx_en)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_byte_q[$];
  int         exp_cyc_q[$];
  int         exp_ferr = 0;

  int         done_cnt = 0, ferr_cnt = 0, rx_en_cnt = 0, busy_cnt = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_done = 1'b0, prev_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      last_good = 8'h00;
      prev_done = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (clk_rx_en) rx_en_cnt++;
      if (busy) busy_cnt++;
      if (done && frame_err) check("done_ferr_exclusive", {done, frame_err}, 2'b10);
      if (done && prev_done) check("done_single_cycle", prev_done, 1'b0);
      if (frame_err && prev_ferr) check("ferr_single_cycle", prev_ferr, 1'b0);
      if (done) begin
        done_cnt++;
        if (exp_byte_q.size() == 0) begin
          check("unexpected_done", dout, 32'hxxxx_xxxx);
        end else begin
          logic [7:0] eb;
          int ec;
          eb = exp_byte_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("dout", dout, eb);
          check("done_latency", cyc, ec);
          last_good = eb;
        end
      end
      if (frame_err) begin
        ferr_cnt++;
        check("dout_hold_on_ferr", dout, last_good);
      end
      prev_done = done;
      prev_ferr = frame_err;
    end
  end

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_done);
    if (expect_done && stop_bit) begin
      exp_byte_q.push_back(b);
      // start edge is cyc+1; done is seen at the negedge before edge LAT.
      exp_cyc_q.push_back(cyc + LAT);
    end
    if (!stop_bit) exp_ferr++;
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_byte_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, (exp_byte_q.size() == 0 && !busy), 1'b1);
    exp_byte_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b0, f0, nfr;
    logic [7:0] rb;
    logic       rs;

    repeat (3) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_en", clk_rx_en, 1'b0);
    rst = 1'b0;
    idle(5);

    // single frame 0x37
    e0 = rx_en_cnt; d0 = done_cnt;
    send_frame(8'h37, 1'b1, 1'b1);
    idle(4);
    drain("f37");
    check("f37_rx_en_pulses", rx_en_cnt - e0, 10);
    check("f37_done_pulses", done_cnt - d0, 1);
    check("f37_dout", dout, 8'h37);
    check("f37_busy", busy, 1'b0);

    // two frames with idle gap
    send_frame(8'h37, 1'b1, 1'b1);
    idle(6);
    send_frame(8'h20, 1'b1, 1'b1);
    idle(4);
    drain("pair");
    check("pair_dout", dout, 8'h20);

    // 2-clock glitch
    b0 = busy_cnt; d0 = done_cnt; f0 = ferr_cnt;
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(12);
    check("glitch_busy_le6", (busy_cnt - b0) <= 6, 1'b1);
    check("glitch_busy_seen", (busy_cnt - b0) > 0, 1'b1);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_idle", busy, 1'b0);

    // framing error then line held low
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    uart_rxd = 1'b0;
    repeat (40) @(negedge clk);
    check("break_busy", busy, 1'b1);
    check("break_no_done", done_cnt - d0, 0);
    idle(4);
    check("break_ferr_once", ferr_cnt - f0, 1);
    check("break_dout_kept", dout, 8'h20);
    check("break_idle", busy, 1'b0);
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, 1'b1, 1'b1);
    idle(3);
    drain("recover");

    // back-to-back, zero gap
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(4);
    drain("b2b");
    check("b2b_dout", dout, 8'h0F);

    // random stream
    e0 = rx_en_cnt; f0 = ferr_cnt;
    nfr = 24;
    for (int i = 0; i < nfr; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs, 1'b1);
      if (rs) idle($urandom_range(0, 3));
      else    idle($urandom_range(3, 6));
    end
    idle(4);
    drain("rand");
    check("rand_rx_en_pulses", rx_en_cnt - e0, 10 * nfr);

    // reset during bit 4 of 0xFF
    d0 = done_cnt; f0 = ferr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT_CLKS * 5 + 3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_dout", dout, 8'h00);
        check("arst_done", done, 1'b0);
        check("arst_ferr", frame_err, 1'b0);
        check("arst_rx_en", clk_rx_en, 1'b0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    drain("post_rst");
    check("post_rst_dout", dout, 8'h3C);

    check("ferr_total", ferr_cnt, exp_ferr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's uart_tx.
- Deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous uart_rxd pin into bytes.
- Bit timing uses the same T_DIV/T_DIV_HALF divider scheme as uart_tx (50 MHz clock, 9,600 baud).
- Sits between the board RX pin and the byte consumer, e.g. loopback against uart_tx.

Parameters:
- T_DIV, 13'd5207: clocks per bit minus 1 (5208 clocks per bit = 9,600 baud at 50 MHz). Simulation builds with SIM defined use 13'd7.
- T_DIV_HALF, 13'd2603: clocks to mid-bit minus 1. Simulation builds with SIM defined use 13'd3.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset, asynchronous, active-high
- uart_rxd  input  1  serial line, asynchronous, idle high
- dout  output  8  last correctly received byte
- done  output  1  one-cycle pulse: dout updated with a new byte
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while state is not IDLE
- clk_rx_en  output  1  one-cycle strobe on every bit-sample instant (debug, mirrors clk_tx_en)

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, dout=8'h00, done=0, frame_err=0, busy=0, clk_rx_en=0. Both synchroniser flops reset to 1 (line idle).
- Synchroniser: uart_rxd passes through 2 flops, giving rxd_s. All logic uses only rxd_s.
- Divider: 13-bit cnt, cleared on every state entry.
- IDLE: when rxd_s==0, go to START.
- START: count to T_DIV_HALF, then sample rxd_s.
  - rxd_s==1: false start, return to IDLE, no flags.
  - rxd_s==0: go to DATA with bit_idx=0.
- DATA: count to T_DIV, then sample rxd_s into shift register bit bit_idx (LSB first). After bit_idx==7 is sampled, go to STOP.
- STOP: count to T_DIV, then sample rxd_s.
  - rxd_s==1: dout<=shift; done=1 for the next cycle; go to IDLE.
  - rxd_s==0: frame_err=1 for the next cycle; dout unchanged; go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. This covers a line held low, so no spurious frames are generated.
- clk_rx_en: high for exactly one cycle at each of the 10 sample instants of a valid frame.
- Latency: done goes high 3 + (T_DIV_HALF+1) + 9*(T_DIV+1) clocks after the first rising edge of clk at which uart_rxd is low. With SIM values this is 79 clocks.
- Back-to-back frames: a start edge arriving in the first cycle after STOP is detected. No dead time is required beyond the stop bit.
- Reset mid-frame: the frame is abandoned immediately; no done and no frame_err.
- done and frame_err are never high in the same cycle.

Decomposition:
- Shared package/include uart_defs.vh holds T_DIV and T_DIV_HALF under the SIM ifdef, plus the state encodings. uart_tx and uart_rx both use these.
- Optional sub-module uart_sync2: a 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.
- The FSM and counters stay in uart_rx.

Test Plan (SIM values, T_CLK = 20 ns):
- Frame 0x37: drive 0 | 1,1,1,0,1,1,0,0 | 1, each bit held 8 clocks -> single done pulse, dout=8'h37, frame_err=0, 10 clk_rx_en pulses, busy returns to 0.
- Loopback: uart_tx.uart_txd drives uart_rx.uart_rxd; send 8'h37 then 8'h20 -> two done pulses, dout=8'h37 then 8'h20, each done 79 clocks after the corresponding start edge.
- Glitch: low pulse of 2 clocks on an idle line -> return to IDLE at the mid-bit check; no done, no frame_err; busy high for 6 clocks at most.
- Framing error: frame 0x55 with stop bit low, then line held low 40 clocks, then high -> frame_err pulses once, dout unchanged, no done; no new frame starts until the line returns high.
- Back-to-back: frames 0xA5 and 0x0F sent with zero idle gap -> two done pulses, dout=8'hA5 then 8'h0F.
- Reset mid-frame: assert rst during bit 4 of frame 0xFF -> outputs go to reset values asynchronously; a following clean frame 0x3C yields done with dout=8'h3C.
